// File: rtl/dsss_tx_ctrl.sv
// DSSS transmit controller: preamble, byte load and PN chip spreading.
// Define DSSS_PREAMBLE_EN to build the preamble state and its counter.
module dsss_tx_ctrl #(
  parameter int unsigned CHIPS_PER_BIT = 15,
  parameter int unsigned PREAMBLE_BITS = 8,
  parameter logic [3:0]  LFSR_SEED     = 4'b1111
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] len,
  input  logic [7:0] din,
  input  logic       din_valid,
  output logic       din_ready,
  output logic       chip,
  output logic       chip_valid,
  output logic       bit_strobe,
  output logic       busy,
  output logic       done,
  output logic       underrun
);

  if (CHIPS_PER_BIT < 1 || CHIPS_PER_BIT > 255) begin : g_bad_cpb
    $error("CHIPS_PER_BIT out of range");
  end
  if (PREAMBLE_BITS < 1 || PREAMBLE_BITS > 255) begin : g_bad_pre
    $error("PREAMBLE_BITS out of range");
  end
  if (LFSR_SEED == 4'd0) begin : g_bad_seed
    $error("LFSR_SEED must be nonzero");
  end

  localparam logic [7:0] LAST_CHIP = 8'(CHIPS_PER_BIT - 1);

`ifdef DSSS_PREAMBLE_EN
  localparam logic [7:0] LAST_PRE = 8'(PREAMBLE_BITS - 1);
  typedef enum logic [2:0] {IDLE, PRE, LOAD, SEND, DONE} state_e;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SEND, DONE} state_e;
`endif

  state_e     state_q, state_d;
  logic [3:0] lfsr_q, lfsr_d;
  logic [7:0] chip_cnt_q, chip_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic [7:0] shift_q, shift_d;
`ifdef DSSS_PREAMBLE_EN
  logic [7:0] pre_cnt_q, pre_cnt_d;
`endif

  logic cv_c, dbit_c, ready_c, under_c, done_c, last_chip_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lfsr_q     <= LFSR_SEED;
      chip_cnt_q <= 8'd0;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= 8'd0;
      shift_q    <= 8'd0;
`ifdef DSSS_PREAMBLE_EN
      pre_cnt_q  <= 8'd0;
`endif
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      chip_cnt_q <= chip_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shift_q    <= shift_d;
`ifdef DSSS_PREAMBLE_EN
      pre_cnt_q  <= pre_cnt_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    chip_cnt_d  = chip_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shift_d     = shift_q;
`ifdef DSSS_PREAMBLE_EN
    pre_cnt_d   = pre_cnt_q;
`endif
    cv_c        = 1'b0;
    dbit_c      = 1'b0;
    ready_c     = 1'b0;
    under_c     = 1'b0;
    done_c      = 1'b0;
    last_chip_c = (chip_cnt_q == LAST_CHIP);

    unique case (state_q)
      IDLE: begin
        if (start && len != 8'd0) begin
          lfsr_d     = LFSR_SEED;
          byte_cnt_d = len;
          chip_cnt_d = 8'd0;
          bit_cnt_d  = 3'd0;
`ifdef DSSS_PREAMBLE_EN
          pre_cnt_d  = 8'd0;
          state_d    = PRE;
`else
          state_d    = LOAD;
`endif
        end
      end
`ifdef DSSS_PREAMBLE_EN
      PRE: begin
        cv_c   = 1'b1;
        dbit_c = 1'b1;
        if (!last_chip_c) begin
          chip_cnt_d = chip_cnt_q + 8'd1;
        end else begin
          chip_cnt_d = 8'd0;
          if (pre_cnt_q == LAST_PRE) begin
            pre_cnt_d = 8'd0;
            state_d   = LOAD;
          end else begin
            pre_cnt_d = pre_cnt_q + 8'd1;
          end
        end
      end
`endif
      LOAD: begin
        ready_c = 1'b1;
        if (din_valid) begin
          shift_d    = din;
          byte_cnt_d = byte_cnt_q - 8'd1;
          chip_cnt_d = 8'd0;
          bit_cnt_d  = 3'd0;
          state_d    = SEND;
        end
      end
      SEND: begin
        cv_c   = 1'b1;
        dbit_c = shift_q[7];
        if (!last_chip_c) begin
          chip_cnt_d = chip_cnt_q + 8'd1;
        end else begin
          chip_cnt_d = 8'd0;
          if (bit_cnt_q != 3'd7) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            shift_d   = {shift_q[6:0], 1'b0};
          end else if (byte_cnt_q == 8'd0) begin
            state_d = DONE;
          end else begin
            // Back-to-back byte keeps the chip stream gap-free
            ready_c = 1'b1;
            if (din_valid) begin
              shift_d    = din;
              byte_cnt_d = byte_cnt_q - 8'd1;
              bit_cnt_d  = 3'd0;
            end else begin
              under_c = 1'b1;
              state_d = LOAD;
            end
          end
        end
      end
      DONE: begin
        done_c  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (cv_c) begin
      lfsr_d = {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
    end
  end

  assign chip_valid = cv_c;
  assign chip       = cv_c & (dbit_c ^ lfsr_q[3]);
  assign bit_strobe = cv_c & (chip_cnt_q == 8'd0);
  assign din_ready  = ready_c;
  assign underrun   = under_c;
  assign done       = done_c;
  assign busy       = (state_q != IDLE);

endmodule
